fb_mem_arbiter: RTL
===================

FB_MEM_ARBITER -- requirements
Module: fb_mem_arbiter

Interface
REQ-001 Parameters SHALL be: DEPTH, default 77500, memory words; ADDR_W, default 17, address width; DATA_W, default 32, data width; STARVE_MAX, default 4, consecutive video grants allowed while the update port waits.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 vid_req  in  1  / vid_addr  in  ADDR_W: scan-out read request and word address.
REQ-005 vid_gnt  out  1  video request accepted this cycle.
REQ-006 vid_rvalid  out  1  / vid_rdata  out  DATA_W: video read data, one cycle after grant.
REQ-007 upd_read  in  1  / upd_write  in  1  / upd_addr  in  ADDR_W  / upd_byteenable  in  4  / upd_writedata  in  DATA_W: Avalon-MM update (game-of-life engine/CPU) port.
REQ-008 upd_waitrequest  out  1  / upd_readdatavalid  out  1  / upd_readdata  out  DATA_W  / upd_err  out  1: update-port responses; upd_err is a one-cycle error pulse.
REQ-009 mem_address  out  ADDR_W  / mem_byteenable  out  4  / mem_chipselect  out  1  / mem_write  out  1  / mem_writedata  out  DATA_W  / mem_clken  out  1  / mem_readdata  in  DATA_W: single-port on-chip RAM, address registered inside RAM, unregistered output.

Function
REQ-010 Grant SHALL be combinational each cycle: GNT_VID, GNT_UPD or GNT_NONE; exactly one requester accesses the RAM per cycle.
REQ-011 Video SHALL win when both request, unless streak counter equals STARVE_MAX, in which case update wins.
REQ-012 Streak counter SHALL increment on each video grant while an update is pending, clear on any update grant or any cycle with no update pending, and saturate at STARVE_MAX.
REQ-013 upd_waitrequest SHALL be low exactly in cycles where update is granted and high otherwise while upd_read or upd_write is asserted; low when idle.
REQ-014 Mem outputs SHALL be driven combinationally from the granted requester; mem_chipselect low on GNT_NONE; mem_write high only for a granted in-range update write.
REQ-015 Read latency SHALL be 1: a registered tag (NONE/VID/UPD) routes mem_readdata to vid_rdata or upd_readdata with its valid in the cycle after grant.
REQ-016 Address >= DEPTH SHALL be accepted (granted) but mem_chipselect held low; a write is dropped, a read returns 0 with valid next cycle, and upd_err pulses the next cycle for update-port accesses.
REQ-017 upd_read and upd_write asserted together SHALL be treated as a write and pulse upd_err the cycle after grant.
REQ-018 mem_clken SHALL be 1 whenever reset is low.
REQ-019 Valids SHALL never be asserted for two requesters in the same cycle; at most one response per cycle.

Reset
REQ-020 While reset is high: vid_gnt, vid_rvalid, upd_readdatavalid, upd_err, mem_chipselect, mem_write, mem_clken = 0; rdata outputs = 0; upd_waitrequest = 1; streak counter and tag cleared.
REQ-021 A read granted in the cycle reset asserts SHALL produce no valid after reset deasserts.

Structure
REQ-022 Package fb_mem_pkg SHALL hold DEPTH, ADDR_W, DATA_W, STARVE_MAX defaults and the grant/tag enum {GNT_NONE, GNT_VID, GNT_UPD}.
REQ-023 No sub-module is required; counter, tag register and grant mux SHALL live in fb_mem_arbiter.

Verification
REQ-024 vid_req only, addr 0x00010, RAM word 0xDEADBEEF -> vid_gnt same cycle, vid_rvalid with 0xDEADBEEF next cycle.
REQ-025 vid_req held continuously plus upd_write addr 0x00020 data 0x12345678 -> 4 video grants, then upd_waitrequest low on 5th cycle, later read of 0x00020 returns 0x12345678.
REQ-026 upd_read addr 77500 -> accepted, mem_chipselect 0, upd_readdatavalid with 0x00000000 and upd_err pulse next cycle.
REQ-027 upd_read and upd_write both high, addr 0x00001, byteenable 0x1 data 0xFF -> treated as write of byte 0 only, upd_err pulse next cycle, no readdatavalid.
REQ-028 reset asserted in cycle of video grant -> no vid_rvalid after release; all outputs at REQ-020 values during reset.

Source files
------------

// File: rtl/fb_mem_pkg.sv
// fb_mem_pkg: shared defaults and grant/tag encoding for the frame-buffer arbiter
package fb_mem_pkg;
  localparam int FB_DEPTH = 77500;
  localparam int FB_ADDR_W = 17;
  localparam int FB_DATA_W = 32;
  localparam int FB_STARVE_MAX = 4;
  typedef enum logic [1:0] {GNT_NONE, GNT_VID, GNT_UPD} gnt_e;
endpackage

// File: rtl/fb_mem_arbiter_if.sv
// fb_mem_arbiter_if: video port, Avalon-MM update port and RAM port of the arbiter
interface fb_mem_arbiter_if #(
  parameter int ADDR_W = fb_mem_pkg::FB_ADDR_W,
  parameter int DATA_W = fb_mem_pkg::FB_DATA_W
);
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_gnt;
  logic              vid_rvalid;
  logic [DATA_W-1:0] vid_rdata;
  logic              upd_read;
  logic              upd_write;
  logic [ADDR_W-1:0] upd_addr;
  logic [3:0]        upd_byteenable;
  logic [DATA_W-1:0] upd_writedata;
  logic              upd_waitrequest;
  logic              upd_readdatavalid;
  logic [DATA_W-1:0] upd_readdata;
  logic              upd_err;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;
  modport slave(
    input  vid_req, vid_addr, upd_read, upd_write, upd_addr, upd_byteenable, upd_writedata, mem_readdata,
    output vid_gnt, vid_rvalid, vid_rdata, upd_waitrequest, upd_readdatavalid, upd_readdata, upd_err,
           mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken
  );
  modport master(
    output vid_req, vid_addr, upd_read, upd_write, upd_addr, upd_byteenable, upd_writedata, mem_readdata,
    input  vid_gnt, vid_rvalid, vid_rdata, upd_waitrequest, upd_readdatavalid, upd_readdata, upd_err,
           mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken
  );
endinterface

// File: rtl/fb_mem_arbiter.sv
// fb_mem_arbiter: single-port RAM shared by video scan-out and an update port, with anti-starvation
module fb_mem_arbiter
  import fb_mem_pkg::*;
#(
  parameter int DEPTH = FB_DEPTH,
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W,
  parameter int STARVE_MAX = FB_STARVE_MAX
) (
  input logic clk,
  input logic reset,
  fb_mem_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [ADDR_W:0] LIM = (ADDR_W + 1)'(DEPTH);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  gnt_e gnt, tag_q;
  logic [SW-1:0] streak;
  logic upd_req, vid_ok, upd_ok, sel_ok, oor_q, rd_q, err_q;
  assign upd_req = bus.upd_read | bus.upd_write;
  assign vid_ok = {1'b0, bus.vid_addr} < LIM;
  assign upd_ok = {1'b0, bus.upd_addr} < LIM;
  // Video wins ties unless the update port has already waited out STARVE_MAX video grants.
  assign gnt = reset ? GNT_NONE
             : (bus.vid_req && !(upd_req && streak == SMAX)) ? GNT_VID
             : upd_req ? GNT_UPD : GNT_NONE;
  assign sel_ok = gnt == GNT_VID ? vid_ok : gnt == GNT_UPD ? upd_ok : 1'b0;
  assign bus.vid_gnt = gnt == GNT_VID;
  assign bus.upd_waitrequest = reset | (upd_req & (gnt != GNT_UPD));
  assign bus.mem_address = gnt == GNT_UPD ? bus.upd_addr : bus.vid_addr;
  assign bus.mem_byteenable = gnt == GNT_UPD ? bus.upd_byteenable : 4'hF;
  assign bus.mem_chipselect = sel_ok;
  assign bus.mem_write = gnt == GNT_UPD && bus.upd_write && upd_ok;
  assign bus.mem_writedata = bus.upd_writedata;
  assign bus.mem_clken = !reset;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tag_q <= GNT_NONE;
      streak <= '0;
      oor_q <= 1'b0;
      rd_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      tag_q <= gnt;
      streak <= (!upd_req || gnt == GNT_UPD) ? '0
              : (gnt == GNT_VID && streak != SMAX) ? streak + SW'(1) : streak;
      oor_q <= !sel_ok;
      rd_q <= bus.upd_read & !bus.upd_write;
      err_q <= gnt == GNT_UPD && (!upd_ok || (bus.upd_read && bus.upd_write));
    end
  // Out-of-range reads never touched the RAM, so their data is forced to zero.
  assign bus.vid_rvalid = tag_q == GNT_VID;
  assign bus.vid_rdata = (tag_q == GNT_VID && !oor_q) ? bus.mem_readdata : {DATA_W{1'b0}};
  assign bus.upd_readdatavalid = tag_q == GNT_UPD && rd_q;
  assign bus.upd_readdata = (tag_q == GNT_UPD && rd_q && !oor_q) ? bus.mem_readdata : {DATA_W{1'b0}};
  assign bus.upd_err = err_q;
endmodule
